chacha20_ks_scheduler: RTL and testbench

CHACHA20_KS_SCHEDULER -- requirements
Module: chacha20_ks_scheduler

---
 rtl/chacha20_ks_scheduler.sv | 168 ++++++++++++++++
 tb/tb_chacha20_ks_scheduler.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chacha20_ks_scheduler.sv
// ChaCha20 keystream scheduler: arbitrates two requesters and sequences the cipher core block by block.
// Optional WAIT watchdog and sticky err are compiled in when CHACHA20_KS_TIMEOUT_EN is defined.
module chacha20_ks_scheduler #(
  parameter int MAX_BLOCKS  = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req,
  input  logic [95:0]  req_nonce0,
  input  logic [95:0]  req_nonce1,
  input  logic [7:0]   req_blocks0,
  input  logic [7:0]   req_blocks1,
  output logic [1:0]   ack,
  output logic [1:0]   ks_valid,
  input  logic [1:0]   ks_ready,
  output logic [511:0] ks_data,
  output logic         ks_last,
  output logic         core_start,
  output logic [95:0]  core_nonce,
  output logic [31:0]  core_counter,
  input  logic [511:0] core_cipher,
  input  logic         core_done,
  output logic         busy,
  output logic         err,
  output logic [2:0]   fsm_state
);

  if (MAX_BLOCKS < 1 || MAX_BLOCKS > 255 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("chacha20_ks_scheduler: MAX_BLOCKS must be 1..255 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT   = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t       state;
  logic         prio;      // requester that wins a tie next time
  logic         owner;     // requester of the transfer in flight
  logic [7:0]   n_blk;
  logic [31:0]  blk_cnt;
  logic         winner;
  logic [7:0]   win_blocks;
  logic [7:0]   win_n;
  logic [95:0]  win_nonce;
  logic         is_last;

  assign fsm_state  = state;
  assign winner     = req[prio] ? prio : ~prio;
  assign win_blocks = winner ? req_blocks1 : req_blocks0;
  assign win_nonce  = winner ? req_nonce1 : req_nonce0;
  assign win_n      = (win_blocks > 8'(MAX_BLOCKS)) ? 8'(MAX_BLOCKS) : win_blocks;
  assign is_last    = (blk_cnt == (32'(n_blk) - 32'd1));

`ifdef CHACHA20_KS_TIMEOUT_EN
  logic        err_q;
  logic [31:0] wait_cnt;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // ks_valid/ks_ready: a block transfers on the cycle ks_valid[i] && ks_ready[i];
  // ks_valid, ks_data and ks_last hold unchanged until that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      prio         <= 1'b0;
      owner        <= 1'b0;
      n_blk        <= 8'd0;
      blk_cnt      <= 32'd0;
      ack          <= 2'b00;
      ks_valid     <= 2'b00;
      ks_data      <= '0;
      ks_last      <= 1'b0;
      core_start   <= 1'b0;
      core_nonce   <= '0;
      core_counter <= 32'd0;
      busy         <= 1'b0;
`ifdef CHACHA20_KS_TIMEOUT_EN
      err_q        <= 1'b0;
      wait_cnt     <= 32'd0;
`endif
    end else begin
      ack        <= 2'b00;
      core_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req) begin
            state <= S_ARB;
            busy  <= 1'b1;
          end
        end
        S_ARB: begin
          if (!(|req)) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            ack     <= winner ? 2'b10 : 2'b01;
            owner   <= winner;
            prio    <= ~winner;
            n_blk   <= win_n;
            blk_cnt <= 32'd0;
            if (win_n == 8'd0) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              state        <= S_START;
              core_start   <= 1'b1;
              core_nonce   <= win_nonce;
              core_counter <= 32'd0;
            end
          end
        end
        S_START: begin
          state <= S_WAIT;
`ifdef CHACHA20_KS_TIMEOUT_EN
          wait_cnt <= 32'd0;
`endif
        end
        S_WAIT: begin
          if (core_done) begin
            ks_data  <= core_cipher;
            ks_valid <= owner ? 2'b10 : 2'b01;
            ks_last  <= is_last;
            state    <= S_OUT;
          end
`ifdef CHACHA20_KS_TIMEOUT_EN
          else if (wait_cnt == 32'(TIMEOUT_CYC - 1)) begin
            state    <= S_ERR;
            err_q    <= 1'b1;
            ks_valid <= 2'b00;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
`endif
        end
        S_OUT: begin
          if (ks_ready[owner]) begin
            ks_valid <= 2'b00;
            ks_last  <= 1'b0;
            if (ks_last) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              blk_cnt      <= blk_cnt + 32'd1;
              core_counter <= blk_cnt + 32'd1;
              core_start   <= 1'b1;
              state        <= S_START;
            end
          end
        end
        // Terminal until reset; requests are deliberately not serviced.
        S_ERR: begin
          state    <= S_ERR;
          ks_valid <= 2'b00;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha20_ks_scheduler.sv
// Self-checking bench for chacha20_ks_scheduler: cipher-core emulator, scoreboard of expected keystream
// blocks built from a transaction-level model, directed scenarios and a randomized phase.
module tb_chacha20_ks_scheduler;
  localparam int MAX_BLOCKS  = 16;
  localparam int TIMEOUT_CYC = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req;
  logic [95:0]  req_nonce0, req_nonce1;
  logic [7:0]   req_blocks0, req_blocks1;
  logic [1:0]   ack, ks_valid, ks_ready;
  logic [511:0] ks_data;
  logic         ks_last, core_start;
  logic [95:0]  core_nonce;
  logic [31:0]  core_counter;
  logic [511:0] core_cipher;
  logic         core_done, busy, err;
  logic [2:0]   fsm_state;

  chacha20_ks_scheduler #(.MAX_BLOCKS(MAX_BLOCKS), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .reset(reset), .req(req),
    .req_nonce0(req_nonce0), .req_nonce1(req_nonce1),
    .req_blocks0(req_blocks0), .req_blocks1(req_blocks1),
    .ack(ack), .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_data(ks_data), .ks_last(ks_last),
    .core_start(core_start), .core_nonce(core_nonce), .core_counter(core_counter),
    .core_cipher(core_cipher), .core_done(core_done),
    .busy(busy), .err(err), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- bench state ----------------
  logic [513:0] exp_q[$];          // {requester, last, data}
  logic [31:0]  start_log[$];
  int           m_ptr = 0;
  int           done_delay = 5;
  bit           rand_delay = 0, rand_ready = 0, noise_en = 0, core_hold = 0;
  int           stall_left = 0;
  int           n_start = 0, n_hs = 0, n_valid_seen = 0;
  bit           core_pend = 0;
  int           core_wait = 0;
  logic [95:0]  cn_l;
  logic [31:0]  cc_l;
  bit           done_prev = 0, hs_prev_nonlast = 0, hs_prev_last = 0, prev_stall = 0;
  logic [1:0]   prev_valid, hs;
  logic [511:0] prev_data;
  logic [513:0] e;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Stand-in for the ChaCha20 block function: any injective-enough mix of nonce and counter.
  function automatic logic [511:0] cipher_of(input logic [95:0] nonce, input logic [31:0] ctr);
    logic [511:0] r;
    for (int i = 0; i < 16; i++)
      r[i*32 +: 32] = (nonce[31:0] + 32'(i) * 32'h9e3779b9) ^ nonce[63:32] ^ {nonce[79:64], ctr[15:0]}
                      ^ (ctr * 32'h01000193) ^ (32'(i) << 8) ^ {nonce[95:80], ctr[31:16]};
    return r;
  endfunction

  task automatic expect_blocks(input int w, input int b, input logic [95:0] nn);
    int n;
    logic wbit;
    n = (b > MAX_BLOCKS) ? MAX_BLOCKS : b;
    wbit = (w == 1);
    for (int c = 0; c < n; c++)
      exp_q.push_back({wbit, (c == n - 1), cipher_of(nn, 32'(c))});
  endtask

  task automatic do_reset();
    req = 2'b00;
    reset = 1'b1;
    exp_q.delete();
    m_ptr = 0;
    stall_left = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ack"}, 512'(ack), 512'(0));
    check({tag, "_ks_valid"}, 512'(ks_valid), 512'(0));
    check({tag, "_ks_data"}, ks_data, 512'(0));
    check({tag, "_ks_last"}, 512'(ks_last), 512'(0));
    check({tag, "_core_start"}, 512'(core_start), 512'(0));
    check({tag, "_core_nonce"}, 512'(core_nonce), 512'(0));
    check({tag, "_core_counter"}, 512'(core_counter), 512'(0));
    check({tag, "_busy"}, 512'(busy), 512'(0));
    check({tag, "_err"}, 512'(err), 512'(0));
  endtask

  task automatic wait_ack(input int limit);
    int guard = 0;
    while (ack == 2'b00 && guard < limit) begin @(negedge clk); guard++; end
  endtask

  // Issue a request set; the model serves pending requesters in round-robin order.
  task automatic run_req(input logic [1:0] mask, input logic [7:0] b0, input logic [7:0] b1);
    logic [1:0] pend;
    int w, guard;
    req_nonce0 = {$urandom(), $urandom(), $urandom()};
    req_nonce1 = {$urandom(), $urandom(), $urandom()};
    req_blocks0 = b0;
    req_blocks1 = b1;
    req = mask;
    pend = mask;
    while (pend != 2'b00) begin
      w = pend[m_ptr] ? m_ptr : 1 - m_ptr;
      wait_ack(2000);
      check("ack_winner", 512'(ack), (w == 1) ? 512'(2) : 512'(1));
      expect_blocks(w, (w == 1) ? int'(b1) : int'(b0), (w == 1) ? req_nonce1 : req_nonce0);
      req[w] = 1'b0;
      pend[w] = 1'b0;
      m_ptr = 1 - w;
      @(negedge clk);
      check("ack_pulse", 512'(ack), 512'(0));
    end
    guard = 0;
    while ((busy || exp_q.size() != 0) && guard < 5000) begin @(negedge clk); guard++; end
    check("drain_q", 512'(exp_q.size()), 512'(0));
    check("idle_busy", 512'(busy), 512'(0));
  endtask

  // ---------------- ready driver, core emulator, scoreboard ----------------
  initial begin
    ks_ready = 2'b11;
    core_done = 1'b0;
    core_cipher = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        core_pend = 0; core_done = 1'b0; done_prev = 0;
        hs_prev_nonlast = 0; hs_prev_last = 0; prev_stall = 0;
      end else begin
        if (ks_valid != 2'b00 && stall_left > 0) begin
          ks_ready = 2'b00;
          stall_left--;
        end else if (rand_ready) ks_ready = 2'($urandom_range(0, 3));
        else ks_ready = 2'b11;

        if (done_prev) check("done_to_valid", 512'(ks_valid != 2'b00), 512'(1));
        if (hs_prev_nonlast) check("hs_to_start", 512'(core_start), 512'(1));
        if (hs_prev_last) check("last_to_idle", 512'(busy), 512'(0));
        if (prev_stall) begin
          check("hold_valid", 512'(ks_valid), 512'(prev_valid));
          check("hold_data", ks_data, prev_data);
          check("no_start_stall", 512'(core_start), 512'(0));
        end
        if (ks_valid != 2'b00) n_valid_seen++;

        hs = ks_valid & ks_ready;
        hs_prev_nonlast = 0;
        hs_prev_last = 0;
        if (hs != 2'b00) begin
          n_hs++;
          check("ks_expected", 512'(exp_q.size() != 0), 512'(1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("ks_who", 512'(hs), e[513] ? 512'(2) : 512'(1));
            check("ks_last", 512'(ks_last), 512'(e[512]));
            check("ks_data", ks_data, e[511:0]);
            if (e[512]) hs_prev_last = 1; else hs_prev_nonlast = 1;
          end
        end
        prev_stall = ((ks_valid & ~ks_ready) != 2'b00);
        prev_valid = ks_valid;
        prev_data  = ks_data;

        done_prev = 0;
        core_done = 1'b0;
        if (core_pend && !core_hold) begin
          if (core_wait == 0) begin
            check("core_ctx_stable", 512'({core_nonce, core_counter}), 512'({cn_l, cc_l}));
            core_done = 1'b1;
            core_cipher = cipher_of(cn_l, cc_l);
            core_pend = 0;
            done_prev = 1;
          end else core_wait--;
        end
        if (core_start) begin
          core_pend = 1;
          cn_l = core_nonce;
          cc_l = core_counter;
          core_wait = rand_delay ? int'($urandom_range(0, 6)) : done_delay;
          n_start++;
          start_log.push_back(core_counter);
        end else if (noise_en && !core_pend && !core_done && $urandom_range(0, 3) == 0) begin
          core_done = 1'b1;
          core_cipher = {16{$urandom()}};
        end
      end
    end
  end

  // ---------------- directed and random scenarios ----------------
  initial begin
    int s0, h0, v0, n_ack, guard;
    reset = 1'b1;
    req = 2'b00;
    req_nonce0 = '0; req_nonce1 = '0;
    req_blocks0 = 8'd0; req_blocks1 = 8'd0;
    repeat (2) @(negedge clk);
    check_outputs_zero("rst");
    reset = 1'b0;
    @(negedge clk);

    // Three blocks for requester 0, fixed core latency.
    done_delay = 5;
    s0 = n_start;
    start_log.delete();
    run_req(2'b01, 8'd3, 8'd0);
    check("t1_starts", 512'(n_start - s0), 512'(3));
    check("t1_log", 512'(start_log.size()), 512'(3));
    for (int i = 0; i < 3 && i < start_log.size(); i++)
      check("t1_ctr", 512'(start_log[i]), 512'(i));

    // Simultaneous requests: pointer alternates.
    do_reset();
    run_req(2'b11, 8'd1, 8'd1);
    run_req(2'b11, 8'd1, 8'd1);

    // Back-pressure in OUT.
    stall_left = 4;
    run_req(2'b01, 8'd2, 8'd0);
    check("t3_stall_used", 512'(stall_left), 512'(0));

    // Zero-block request.
    s0 = n_start;
    req_blocks0 = 8'd0;
    req = 2'b01;
    @(negedge clk);
    check("z_busy_arb", 512'(busy), 512'(1));
    check("z_ack_early", 512'(ack), 512'(0));
    @(negedge clk);
    check("z_ack", 512'(ack), 512'(1));
    check("z_busy_idle", 512'(busy), 512'(0));
    req = 2'b00;
    m_ptr = 1;
    repeat (3) @(negedge clk);
    check("z_no_start", 512'(n_start - s0), 512'(0));
    check("z_ack_gone", 512'(ack), 512'(0));

    // Oversized request is clamped.
    s0 = n_start;
    h0 = n_hs;
    run_req(2'b01, 8'd200, 8'd0);
    check("clamp_starts", 512'(n_start - s0), 512'(MAX_BLOCKS));
    check("clamp_blocks", 512'(n_hs - h0), 512'(MAX_BLOCKS));

    // Reset while waiting on the core for block 2 of 3.
    do_reset();
    req_nonce0 = {$urandom(), $urandom(), $urandom()};
    req_blocks0 = 8'd3;
    req = 2'b01;
    h0 = n_hs;
    wait_ack(100);
    check("r_ack", 512'(ack), 512'(1));
    expect_blocks(0, 3, req_nonce0);
    req = 2'b00;
    guard = 0;
    while (n_hs == h0 && guard < 200) begin @(negedge clk); guard++; end
    guard = 0;
    while (!core_start && guard < 20) begin @(negedge clk); guard++; end
    check("r_second_start", 512'(core_start), 512'(1));
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check_outputs_zero("rst_async");
    exp_q.delete();
    v0 = n_valid_seen;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_ptr = 0;
    repeat (20) @(negedge clk);
    check("r_no_valid", 512'(n_valid_seen - v0), 512'(0));
    start_log.delete();
    run_req(2'b01, 8'd2, 8'd0);
    check("r_ctr_restart", 512'(start_log.size() > 0 ? start_log[0] : 32'hffff_ffff), 512'(0));

`ifdef CHACHA20_KS_TIMEOUT_EN
    // Withheld core_done trips the watchdog.
    do_reset();
    core_hold = 1;
    req_blocks0 = 8'd2;
    req = 2'b01;
    wait_ack(100);
    check("to_ack", 512'(ack), 512'(1));
    req = 2'b00;
    guard = 0;
    while (!core_start && guard < 20) begin @(negedge clk); guard++; end
    repeat (TIMEOUT_CYC) @(negedge clk);
    check("to_err_early", 512'(err), 512'(0));
    @(negedge clk);
    check("to_err", 512'(err), 512'(1));
    check("to_busy", 512'(busy), 512'(1));
    check("to_valid", 512'(ks_valid), 512'(0));
    req = 2'b11;
    n_ack = 0;
    repeat (30) begin @(negedge clk); if (ack != 2'b00) n_ack++; end
    check("to_no_ack", 512'(n_ack), 512'(0));
    check("to_err_sticky", 512'(err), 512'(1));
    do_reset();
    core_hold = 0;
    check("to_err_cleared", 512'(err), 512'(0));
`else
    // Without the watchdog, WAIT is unbounded and err stays low.
    core_hold = 1;
    req_nonce0 = {$urandom(), $urandom(), $urandom()};
    req_blocks0 = 8'd1;
    req = 2'b01;
    wait_ack(100);
    check("nw_ack", 512'(ack), (m_ptr == 1 && 1'b0) ? 512'(2) : 512'(1));
    expect_blocks(0, 1, req_nonce0);
    req = 2'b00;
    m_ptr = 1;
    repeat (100) @(negedge clk);
    check("nw_err", 512'(err), 512'(0));
    check("nw_busy", 512'(busy), 512'(1));
    check("nw_valid", 512'(ks_valid), 512'(0));
    core_hold = 0;
    guard = 0;
    while ((busy || exp_q.size() != 0) && guard < 200) begin @(negedge clk); guard++; end
    check("nw_drain", 512'(exp_q.size()), 512'(0));
`endif

    // Randomized traffic: random masks, sizes, core latency, back-pressure and stray core_done.
    rand_ready = 1;
    rand_delay = 1;
    noise_en = 1;
    for (int t = 0; t < 25; t++)
      run_req(2'($urandom_range(1, 3)),
              ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 4)),
              ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 4)));
    rand_ready = 0;
    rand_delay = 0;
    noise_en = 0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    n_fail++;
    $display("FAIL global_timeout: got no completion expected completion within 90000 cycles");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "simulation time limit");
  end

endmodule
